// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types and constants used by the fetch/decode boundary.
package riscv_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } fetch_beat_t;

endpackage

// File: rtl/inst_fetch_buffer.sv
// Decoupling FIFO between the instruction-memory read port and decode.
// Presents NOP bubbles when empty and discards wrong-path beats after a redirect flush.
module inst_fetch_buffer
  import riscv_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int DROP_BEATS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_inst,
  output logic        fetch_ready,
  output logic        dec_valid,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_inst,
  input  logic        dec_ready,
  input  logic        flush
);

  localparam int PTR_W  = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int DROP_W = (DROP_BEATS < 1) ? 1 : $clog2(DROP_BEATS + 1);

  fetch_beat_t mem_q [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic        push;
  logic        pop;
  fetch_beat_t head;

  // Handshake: a beat transfers on a cycle where valid and ready are both high.
  // Upstream holds fetch_* stable while fetch_valid & !fetch_ready; fetch_ready
  // depends only on registered state so there is no path from dec_ready.
  assign fetch_ready = (count_q != CNT_W'(DEPTH));
  assign dec_valid   = (count_q != '0);

  assign push = fetch_valid & fetch_ready & ~flush & (drop_cnt_q == '0);
  assign pop  = dec_valid & dec_ready & ~flush;

  assign head     = mem_q[rd_ptr_q];
  assign dec_pc   = dec_valid ? head.pc   : '0;
  assign dec_inst = dec_valid ? head.inst : NOP_INST;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    if (flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      drop_cnt_d = DROP_W'(DROP_BEATS);
    end else begin
      // Stale beats already in flight from IMEM are swallowed one per valid cycle.
      if ((drop_cnt_q != '0) && fetch_valid) drop_cnt_d = drop_cnt_q - 1'b1;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage contents are don't-care until written, so no reset here.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{pc: fetch_pc, inst: fetch_inst};
  end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Bench for inst_fetch_buffer: directed scenarios plus random traffic against a queue model.
module tb_inst_fetch_buffer;

  localparam int          DEPTH      = 2;
  localparam int          DROP_BEATS = 1;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_inst;
  logic        fetch_ready;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [31:0] dec_inst;
  logic        dec_ready;
  logic        flush;

  logic [63:0] exp_q[$];
  int          m_drop;
  int          n_total;
  int          n_bad;
  logic        consumed;

  inst_fetch_buffer #(.DEPTH(DEPTH), .DROP_BEATS(DROP_BEATS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .fetch_inst  (fetch_inst),
    .fetch_ready (fetch_ready),
    .dec_valid   (dec_valid),
    .dec_pc      (dec_pc),
    .dec_inst    (dec_inst),
    .dec_ready   (dec_ready),
    .flush       (flush)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // reference model: queue of expected beats plus drop-window counter
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_drop = 0;
    end else begin
      logic m_push, m_pop;
      m_push = fetch_valid && (exp_q.size() != DEPTH) && !flush && (m_drop == 0);
      m_pop  = (exp_q.size() != 0) && dec_ready && !flush;
      if (flush) begin
        exp_q.delete();
        m_drop = DROP_BEATS;
      end else begin
        if ((m_drop != 0) && fetch_valid) m_drop = m_drop - 1;
        if (m_pop) void'(exp_q.pop_front());
        if (m_push) exp_q.push_back({fetch_pc, fetch_inst});
      end
    end
  end

  // scoreboard: compare presented head against the model every cycle
  always @(negedge clk) begin
    check("fetch_ready", 64'(fetch_ready), 64'(exp_q.size() != DEPTH));
    check("dec_valid", 64'(dec_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("head", {dec_pc, dec_inst}, exp_q[0]);
    end else begin
      check("bubble", {dec_pc, dec_inst}, {32'h0, NOP});
    end
  end

  // driver tasks (called at posedge+1)
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] inst);
    logic done;
    done        = 1'b0;
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    fetch_inst  = inst;
    for (int i = 0; i < 16 && !done; i++) begin
      @(negedge clk);
      done = fetch_ready;
      @(posedge clk);
      #1;
    end
    if (!done) check("offer_timeout", 64'(0), 64'(1));
    fetch_valid = 1'b0;
  endtask

  task automatic do_flush(input logic v, input logic [31:0] pc);
    flush       = 1'b1;
    fetch_valid = v;
    fetch_pc    = pc;
    fetch_inst  = 32'h0000_0093;
    @(posedge clk);
    #1;
    flush       = 1'b0;
    fetch_valid = 1'b0;
  endtask

  initial begin
    n_total     = 0;
    n_bad       = 0;
    rst_n       = 1'b0;
    fetch_valid = 1'b0;
    fetch_pc    = '0;
    fetch_inst  = '0;
    dec_ready   = 1'b0;
    flush       = 1'b0;

    // 1: reset values before any clock edge
    #1;
    check("rst_dec_valid", 64'(dec_valid), 64'(0));
    check("rst_dec_inst", 64'(dec_inst), 64'(NOP));
    check("rst_dec_pc", 64'(dec_pc), 64'(0));
    check("rst_fetch_ready", 64'(fetch_ready), 64'(1));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(1);

    // 2: streaming
    dec_ready = 1'b1;
    offer(32'h1000, 32'h0050_0093);
    offer(32'h1004, 32'h00A0_0113);
    idle(3);

    // 3: backpressure with a held beat
    dec_ready = 1'b0;
    offer(32'h2000, 32'h0000_0001);
    offer(32'h2004, 32'h0000_0002);
    fetch_valid = 1'b1;
    fetch_pc    = 32'h2008;
    fetch_inst  = 32'h0000_0003;
    idle(2);
    @(negedge clk);
    check("bp_full_ready", 64'(fetch_ready), 64'(0));
    check("bp_head", 64'(dec_pc), 64'(32'h2000));
    @(posedge clk);
    #1;
    dec_ready = 1'b1;
    offer(32'h2008, 32'h0000_0003);
    idle(4);

    // 4: flush with count=2, one drop beat, then recovery
    dec_ready = 1'b0;
    offer(32'h3100, 32'h0000_0011);
    offer(32'h3104, 32'h0000_0012);
    do_flush(1'b1, 32'h3000);
    @(negedge clk);
    check("flush_dec_valid", 64'(dec_valid), 64'(0));
    @(posedge clk);
    #1;
    offer(32'h3004, 32'h0000_0014);
    offer(32'h4000, 32'h0000_0015);
    @(negedge clk);
    check("post_drop_valid", 64'(dec_valid), 64'(1));
    check("post_drop_pc", 64'(dec_pc), 64'(32'h4000));
    @(posedge clk);
    #1;
    dec_ready = 1'b1;
    idle(2);

    // 5: simultaneous push and pop at count=1
    dec_ready = 1'b0;
    offer(32'h5000, 32'h0000_0021);
    dec_ready = 1'b1;
    offer(32'h5004, 32'h0000_0022);
    dec_ready = 1'b0;
    @(negedge clk);
    check("pp_valid", 64'(dec_valid), 64'(1));
    check("pp_head", 64'(dec_pc), 64'(32'h5004));
    @(posedge clk);
    #1;
    dec_ready = 1'b1;
    idle(2);

    // 6: mid-stream reset with count=2
    dec_ready = 1'b0;
    offer(32'h6000, 32'h0000_0031);
    offer(32'h6004, 32'h0000_0032);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(dec_valid), 64'(0));
    check("mid_rst_inst", 64'(dec_inst), 64'(NOP));
    check("mid_rst_pc", 64'(dec_pc), 64'(0));
    check("mid_rst_ready", 64'(fetch_ready), 64'(1));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    offer(32'h0000_0000, 32'h0000_0041);
    @(negedge clk);
    check("after_rst_valid", 64'(dec_valid), 64'(1));
    check("after_rst_inst", 64'(dec_inst), 64'(32'h0000_0041));
    @(posedge clk);
    #1;
    dec_ready = 1'b1;
    idle(2);

    // random traffic with occasional flushes
    consumed = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!(fetch_valid && !consumed)) begin
        fetch_valid = 1'($urandom_range(0, 1));
        fetch_pc    = $urandom;
        fetch_inst  = $urandom;
      end
      dec_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      consumed = fetch_ready || flush;
      @(posedge clk);
      #1;
    end
    fetch_valid = 1'b0;
    flush       = 1'b0;
    dec_ready   = 1'b1;
    idle(4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
